// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one RAM port between the I- and D-cache ports of CPUS cores.
// Ports: CLK/RST, per-core iREN/iaddr/iwait/iload, dREN/dWEN/daddr/dstore/dwait/dload, err, RAM side ram*.
module ram_arbiter #(
  parameter int CPUS    = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int RR_MODE = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [CPUS-1:0]    iREN,
  input  logic [CPUS*AW-1:0] iaddr,
  output logic [CPUS-1:0]    iwait,
  output logic [CPUS*DW-1:0] iload,
  input  logic [CPUS-1:0]    dREN,
  input  logic [CPUS-1:0]    dWEN,
  input  logic [CPUS*AW-1:0] daddr,
  input  logic [CPUS*DW-1:0] dstore,
  output logic [CPUS-1:0]    dwait,
  output logic [CPUS*DW-1:0] dload,
  output logic [CPUS-1:0]    err,
  output logic [AW-1:0]      ramaddr,
  output logic [DW-1:0]      ramstore,
  output logic               ramREN,
  output logic               ramWEN,
  input  logic [DW-1:0]      ramload,
  input  logic [1:0]         ramstate
);

  localparam int GW  = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam int GW1 = GW + 1;

  localparam logic ARB  = 1'b0;
  localparam logic HOLD = 1'b1;

  localparam logic [1:0] ST_ERROR = 2'd3;

  logic          state_q, state_d;
  logic [GW-1:0] rr_q, rr_d;
  logic [GW-1:0] gcore_q, gcore_d;
  logic          gdata_q, gdata_d;

  logic [CPUS-1:0] dreq;
  logic [CPUS-1:0] elig;

  assign dreq = dREN | dWEN;
  assign elig = dreq | iREN;

  // Rotate eligibility so the search always starts at bit 0,
  // then map the hit back to a real core index.
  logic [CPUS-1:0] rot;
  logic [GW-1:0]   base;
  logic [GW-1:0]   sel;
  logic [GW1-1:0]  idx;
  logic            found;

  always_comb begin
    base  = (RR_MODE != 0) ? rr_q : '0;
    rot   = CPUS'({elig, elig} >> base);
    sel   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < CPUS; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        idx   = {1'b0, base} + GW1'(i);
        if (idx >= GW1'(CPUS)) begin
          idx = idx - GW1'(CPUS);
        end
        sel = idx[GW-1:0];
      end
    end
  end

  logic          g_dren, g_dwen, g_iren;
  logic [AW-1:0] g_daddr, g_iaddr;
  logic [DW-1:0] g_dstore;

  always_comb begin
    g_dren   = 1'b0;
    g_dwen   = 1'b0;
    g_iren   = 1'b0;
    g_daddr  = '0;
    g_iaddr  = '0;
    g_dstore = '0;
    for (int k = 0; k < CPUS; k++) begin
      if (gcore_q == GW'(k)) begin
        g_dren   = dREN[k];
        g_dwen   = dWEN[k];
        g_iren   = iREN[k];
        g_daddr  = daddr[k*AW +: AW];
        g_iaddr  = iaddr[k*AW +: AW];
        g_dstore = dstore[k*DW +: DW];
      end
    end
  end

  logic hold, greq, done, abort_req;

  // ramstate[1] set means ACCESS or ERROR, i.e. the RAM has finished.
  assign hold      = (state_q == HOLD) & ~RST;
  assign greq      = gdata_q ? (g_dren | g_dwen) : g_iren;
  assign done      = hold & ramstate[1];
  assign abort_req = hold & ~greq & ~ramstate[1];

  assign ramREN   = hold & (gdata_q ? (g_dren & ~g_dwen) : 1'b1);
  assign ramWEN   = hold & gdata_q & g_dwen;
  assign ramaddr  = hold ? (gdata_q ? g_daddr : g_iaddr) : '0;
  assign ramstore = (hold & gdata_q) ? g_dstore : '0;

  logic hit;

  always_comb begin
    iwait = '0;
    dwait = '0;
    iload = '0;
    dload = '0;
    err   = '0;
    hit   = 1'b0;
    for (int k = 0; k < CPUS; k++) begin
      hit      = done & (gcore_q == GW'(k));
      iwait[k] = iREN[k] & ~(hit & ~gdata_q);
      dwait[k] = dreq[k] & ~(hit & gdata_q);
      err[k]   = hit & (ramstate == ST_ERROR);
      if (hit & ~gdata_q) begin
        iload[k*DW +: DW] = ramload;
      end
      if (hit & gdata_q) begin
        dload[k*DW +: DW] = ramload;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gcore_d = gcore_q;
    gdata_d = gdata_q;
    unique case (1'b1)
      (state_q == ARB): begin
        if (found) begin
          state_d = HOLD;
          gcore_d = sel;
          gdata_d = dreq[sel];
        end
      end
      (state_q == HOLD): begin
        if (done) begin
          state_d = ARB;
          if (RR_MODE != 0) begin
            rr_d = (gcore_q == GW'(CPUS - 1)) ? '0 : gcore_q + GW'(1);
          end
        end else if (abort_req) begin
          state_d = ARB;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ARB;
      rr_q    <= '0;
      gcore_q <= '0;
      gdata_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gcore_q <= gcore_d;
      gdata_q <= gdata_d;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed and random checks of ram_arbiter (4 cores),
// round-robin and fixed-priority instances driven with identical stimulus.
module tb_ram_arbiter;

  localparam int N = 4;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  logic [N-1:0]    iREN, dREN, dWEN;
  logic [N*32-1:0] iaddr, daddr, dstore;
  logic [31:0]     ramload;
  logic [1:0]      ramstate;

  logic [N-1:0]    iwait [2];
  logic [N-1:0]    dwait [2];
  logic [N-1:0]    err [2];
  logic [N*32-1:0] iload [2];
  logic [N*32-1:0] dload [2];
  logic [31:0]     ramaddr [2];
  logic [31:0]     ramstore [2];
  logic            ramREN [2];
  logic            ramWEN [2];

  ram_arbiter #(.CPUS(N), .AW(32), .DW(32), .RR_MODE(1)) u_rr (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait[0]), .iload(iload[0]),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait[0]), .dload(dload[0]), .err(err[0]),
    .ramaddr(ramaddr[0]), .ramstore(ramstore[0]),
    .ramREN(ramREN[0]), .ramWEN(ramWEN[0]),
    .ramload(ramload), .ramstate(ramstate)
  );

  ram_arbiter #(.CPUS(N), .AW(32), .DW(32), .RR_MODE(0)) u_fp (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait[1]), .iload(iload[1]),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait[1]), .dload(dload[1]), .err(err[1]),
    .ramaddr(ramaddr[1]), .ramstore(ramstore[1]),
    .ramREN(ramREN[1]), .ramWEN(ramWEN[1]),
    .ramload(ramload), .ramstate(ramstate)
  );

  int npass = 0;
  int ntot  = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
  endtask

  // Reference model: m=0 round-robin, m=1 fixed priority.
  bit m_hold [2];
  int m_g [2];
  bit m_d [2];
  int m_rr [2];

  function automatic bit has_d(int k);
    return dREN[k] | dWEN[k];
  endfunction

  function automatic bit has_any(int k);
    return dREN[k] | dWEN[k] | iREN[k];
  endfunction

  task automatic look();
    @(negedge CLK);
    for (int m = 0; m < 2; m++) begin
      bit h, dn, eren, ewen;
      int g;
      logic [31:0] eaddr;
      logic [N-1:0] edw, eiw, eerr;
      g     = m_g[m];
      h     = m_hold[m] && !RST;
      dn    = h && (ramstate >= 2);
      eren  = h && (m_d[m] ? (dREN[g] && !dWEN[g]) : 1'b1);
      ewen  = h && m_d[m] && dWEN[g];
      eaddr = !h ? 32'h0 : (m_d[m] ? daddr[g*32 +: 32] : iaddr[g*32 +: 32]);
      eerr  = (dn && ramstate == 2'd3) ? N'(1 << g) : '0;
      for (int k = 0; k < N; k++) begin
        edw[k] = has_d(k) && !(dn && g == k && m_d[m]);
        eiw[k] = iREN[k] && !(dn && g == k && !m_d[m]);
      end
      chk($sformatf("m%0d_ramREN", m), ramREN[m], eren);
      chk($sformatf("m%0d_ramWEN", m), ramWEN[m], ewen);
      chk($sformatf("m%0d_ramaddr", m), ramaddr[m], eaddr);
      chk($sformatf("m%0d_dwait", m), dwait[m], edw);
      chk($sformatf("m%0d_iwait", m), iwait[m], eiw);
      chk($sformatf("m%0d_err", m), err[m], eerr);
      if (ewen)
        chk($sformatf("m%0d_ramstore", m), ramstore[m], dstore[g*32 +: 32]);
      if (dn && m_d[m])
        chk($sformatf("m%0d_dload", m), dload[m][g*32 +: 32], ramload);
      if (dn && !m_d[m])
        chk($sformatf("m%0d_iload", m), iload[m][g*32 +: 32], ramload);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    for (int m = 0; m < 2; m++) begin
      if (RST) begin
        m_hold[m] = 0;
        m_g[m]    = 0;
        m_d[m]    = 0;
        m_rr[m]   = 0;
      end else if (!m_hold[m]) begin
        for (int i = 0; i < N; i++) begin
          int k;
          k = (m == 0) ? (m_rr[m] + i) % N : i;
          if (!m_hold[m] && has_any(k)) begin
            m_hold[m] = 1;
            m_g[m]    = k;
            m_d[m]    = has_d(k);
          end
        end
      end else if (ramstate >= 2) begin
        m_hold[m] = 0;
        if (m == 0) m_rr[m] = (m_g[m] + 1) % N;
      end else if (!(m_d[m] ? has_d(m_g[m]) : iREN[m_g[m]])) begin
        m_hold[m] = 0;
      end
    end
    #1;
  endtask

  task automatic pulse_reset();
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  initial begin
    RST      = 1'b1;
    iREN     = '0;
    dREN     = '0;
    dWEN     = '0;
    ramstate = 2'd0;
    ramload  = '0;
    for (int k = 0; k < N; k++) begin
      iaddr[k*32 +: 32]  = 32'h200 + 32'(k * 4);
      daddr[k*32 +: 32]  = 32'h100 + 32'(k * 4);
      dstore[k*32 +: 32] = 32'h5000 + 32'(k);
    end
    for (int m = 0; m < 2; m++) begin
      m_hold[m] = 0; m_g[m] = 0; m_d[m] = 0; m_rr[m] = 0;
    end
    #1;
    look();
    chk("rst_ramREN", ramREN[0], 1'b0);
    chk("rst_ramWEN", ramWEN[0], 1'b0);
    chk("rst_err", err[0], 4'h0);
    tick();
    RST = 1'b0;

    // single data read with two BUSY cycles
    daddr[31:0] = 32'h40;
    dREN[0]     = 1'b1;
    look();
    chk("t1_arb_ren", ramREN[0], 1'b0);
    tick();
    ramstate = 2'd1;
    look();
    chk("t1_ren", ramREN[0], 1'b1);
    chk("t1_addr", ramaddr[0], 32'h40);
    chk("t1_wait_busy", dwait[0][0], 1'b1);
    tick();
    look();
    chk("t1_wait_busy2", dwait[0][0], 1'b1);
    tick();
    ramstate = 2'd2;
    ramload  = 32'hDEADBEEF;
    look();
    chk("t1_wait_acc", dwait[0][0], 1'b0);
    chk("t1_dload", dload[0][31:0], 32'hDEADBEEF);
    tick();
    dREN[0]  = 1'b0;
    ramstate = 2'd0;

    // data write beats instruction read on the same core
    daddr[31:0]  = 32'h80;
    dstore[31:0] = 32'h1234;
    iREN[0]      = 1'b1;
    dWEN[0]      = 1'b1;
    ramstate     = 2'd2;
    look();
    tick();
    look();
    chk("t2_wen", ramWEN[0], 1'b1);
    chk("t2_store", ramstore[0], 32'h1234);
    chk("t2_iwait", iwait[0][0], 1'b1);
    tick();
    dWEN[0] = 1'b0;
    look();
    chk("t2_arb_gap", ramREN[0], 1'b0);
    tick();
    look();
    chk("t2_iren", ramREN[0], 1'b1);
    chk("t2_iaddr", ramaddr[0], 32'h200);
    chk("t2_iwait_acc", iwait[0][0], 1'b0);
    tick();
    iREN[0] = 1'b0;

    // all cores request: RR rotates, fixed priority stays on core 0
    daddr[31:0] = 32'h100;
    pulse_reset();
    dREN = 4'hF;
    for (int n = 0; n < 5; n++) begin
      look();
      tick();
      look();
      chk($sformatf("t3_rr_grant%0d", n), ramaddr[0], 32'h100 + 32'((n % 4) * 4));
      chk($sformatf("t3_fp_grant%0d", n), ramaddr[1], 32'h100);
      chk($sformatf("t3_fp_wait%0d", n), dwait[1][3:1], 3'b111);
      tick();
    end
    dREN = '0;

    // abort on request drop, pointer unchanged
    pulse_reset();
    ramstate = 2'd1;
    dREN[1]  = 1'b1;
    look();
    tick();
    look();
    chk("t4_grant1", ramaddr[0], 32'h104);
    tick();
    dREN[1] = 1'b0;
    look();
    chk("t4_noerr", err[0], 4'h0);
    tick();
    dREN     = 4'b0101;
    ramstate = 2'd2;
    look();
    chk("t4_arb", ramREN[0], 1'b0);
    tick();
    look();
    chk("t4_rr_kept", ramaddr[0], 32'h100);
    tick();
    dREN = '0;

    // error completion
    dWEN[3]  = 1'b1;
    ramstate = 2'd3;
    look();
    chk("t5_err_arb", err[0], 4'h0);
    tick();
    look();
    chk("t5_err", err[0], 4'b1000);
    chk("t5_wait", dwait[0][3], 1'b0);
    tick();
    dWEN[3] = 1'b0;
    look();
    chk("t5_err_gone", err[0], 4'h0);
    tick();

    // reset in the middle of a BUSY access
    ramstate = 2'd1;
    dREN[2]  = 1'b1;
    look();
    tick();
    look();
    chk("t6_ren", ramREN[0], 1'b1);
    tick();
    RST = 1'b1;
    look();
    chk("t6_ren_rst", ramREN[0], 1'b0);
    tick();
    RST = 1'b0;
    look();
    chk("t6_arb", ramREN[0], 1'b0);
    chk("t6_wait", dwait[0][2], 1'b1);
    tick();
    look();
    chk("t6_regrant", ramaddr[0], 32'h108);
    tick();
    ramstate = 2'd2;
    look();
    tick();
    dREN = '0;

    // random traffic against the model
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          iREN[k] = 1'($urandom_range(0, 1));
          dREN[k] = 1'($urandom_range(0, 1));
          dWEN[k] = ($urandom_range(0, 2) == 0);
        end
        if ($urandom_range(0, 15) == 0) begin
          iaddr[k*32 +: 32]  = $urandom;
          daddr[k*32 +: 32]  = $urandom;
          dstore[k*32 +: 32] = $urandom;
        end
      end
      ramstate = 2'($urandom_range(0, 3));
      ramload  = $urandom;
      RST      = ($urandom_range(0, 59) == 0);
      look();
      tick();
    end
    RST = 1'b0;

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Parametrised N-core arbiter that multiplexes every core's instruction and data cache ports onto the single RAM port.
- Generalises the fixed two-CPU memory control to CPUS cores.
- Adds a selectable policy (round-robin or fixed priority), a registered grant that is held until the RAM completes, abort on request drop, and error reporting.
- Sits between the per-core caches and the RAM interface inside the multicore top.

Parameters:
- CPUS, 2, number of cores (1..8).
- AW, 32, address width.
- DW, 32, data word width.
- RR_MODE, 1, 1 = round-robin among cores, 0 = fixed priority (lowest core index wins).

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous active-high reset.
- iREN  in  CPUS  per-core instruction read request.
- iaddr  in  CPUS*AW  per-core instruction address; core k occupies slice [k*AW +: AW].
- iwait  out  CPUS  per-core instruction wait.
- iload  out  CPUS*DW  per-core instruction read data.
- dREN  in  CPUS  per-core data read request.
- dWEN  in  CPUS  per-core data write request.
- daddr  in  CPUS*AW  per-core data address.
- dstore  in  CPUS*DW  per-core write data.
- dwait  out  CPUS  per-core data wait.
- dload  out  CPUS*DW  per-core data read data.
- err  out  CPUS  one-cycle pulse when the granted access of core k ends in ramstate ERROR.
- ramaddr  out  AW  RAM address.
- ramstore  out  DW  RAM write data.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramload  in  DW  RAM read data.
- ramstate  in  2  RAM state: FREE=0, BUSY=1, ACCESS=2, ERROR=3.

Behaviour:
- Request definition: data request of core k = dREN[k] | dWEN[k]. If both are set, dWEN wins. Instruction request = iREN[k].
- Priority: within the selected core, a data request beats an instruction request. A core is eligible if it has either request.
- Core selection:
  - RR_MODE=1: the first eligible core at or after pointer rr, wrapping from CPUS-1 to 0.
  - RR_MODE=0: the lowest eligible index.
- FSM states ARB and HOLD.
  - ARB: if any core is eligible, register gcore (core index) and gdata (1 = data access), go to HOLD. Otherwise stay in ARB.
  - HOLD: drive the RAM from the registered grant.
    - ramaddr/ramstore come from the granted slice.
    - gdata=1: ramWEN = dWEN[gcore], ramREN = dREN[gcore] & ~dWEN[gcore].
    - gdata=0: ramREN = 1, ramWEN = 0.
  - HOLD exit on ACCESS or ERROR: go to ARB.
  - HOLD abort: if the granted request drops while still BUSY/FREE, go to ARB with no ack and no err.
- Completion handshake:
  - dwait[gcore] or iwait[gcore] is deasserted combinationally in the cycle ramstate==ACCESS or ERROR while in HOLD.
  - dload/iload of gcore = ramload in that cycle.
  - err[gcore] pulses in the cycle ramstate==ERROR.
- wait rule: wait = 1 whenever the corresponding request is asserted and that completion condition is absent. wait = 0 when the request is not asserted.
- Round-robin pointer update: on completion (ACCESS or ERROR) in RR_MODE=1, rr <= (gcore+1) mod CPUS. The pointer is not updated on abort.
- Latency: a request sampled in ARB at edge t is driven on the RAM from t+1. Back-to-back grants are separated by exactly one ARB cycle.
- In ARB: ramREN = ramWEN = 0, ramaddr = 0, ramstore = 0.
- Reset value: on RST high at a clock edge, state <= ARB, rr <= 0, gcore <= 0, gdata <= 0. Reset mid-HOLD drops the access with no ack.
- Reset outputs: ramREN = ramWEN = 0, err = 0, and waits follow the wait rule.
- Simultaneous events: requests arriving during HOLD wait; they are never preempted. A fresh request from gcore in the completing cycle is re-arbitrated normally in ARB.
- CPUS=1: round-robin degenerates to a single core; the pointer stays 0.

Test Plan:
- Single core 0 sets dREN=1, daddr=0x40; RAM returns BUSY for 2 cycles then ACCESS with ramload=0xDEADBEEF. Required: ramREN high from the cycle after request; dwait0 low only in the ACCESS cycle; dload0=0xDEADBEEF.
- Core 0 asserts iREN and dWEN (daddr=0x80, dstore=0x1234) together. Required: the data write is granted first (ramWEN=1, ramstore=0x1234); the instruction read is granted one ARB cycle after the write's ACCESS.
- CPUS=4, RR_MODE=1, all cores request continuously with a 1-cycle ACCESS. Required: grant order 0,1,2,3,0 and each core is served within 4 grants.
- Same stimulus with RR_MODE=0. Required: core 0 is granted every time; cores 1-3 stay in wait.
- Core 1 granted, RAM BUSY, core 1 drops dREN. Required: return to ARB next cycle, no err, rr unchanged. Separately, ramstate=ERROR in HOLD. Required: err[gcore] pulses one cycle and the wait is released.
- RST asserted during HOLD with BUSY. Required: ramREN=0 next cycle, state ARB, rr=0. A request after reset is granted normally.
